// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide controller: 32-step shift-add multiply or restoring divide
// on operand magnitudes, sign fix-up, then a one-cycle HI/LO write pulse.
module hilo_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stallreq,
    output logic        busy,
    output logic        done,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  cnt_r;
    logic [1:0]  op_r;
    logic [63:0] a_r;
    logic [63:0] acc_r;
    logic [31:0] b_r;
    logic        sign_a_r;
    logic        sign_b_r;
    logic        div0_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    logic        accept_s;
    logic        div0_s;
    logic [32:0] shift_s;
    logic [33:0] diff_s;
    logic        qbit_s;
    logic [63:0] prod_add_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return (~x) + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return (~x) + 64'd1;
    endfunction

    // Signed ops (op[0]==0) work on magnitudes; unsigned ops pass operands through.
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? neg32(x) : x;
    endfunction

    assign accept_s = (state_r == IDLE) && start && !flush;
    assign div0_s   = op[1] && (src_b == 32'd0);

    // One multiply or divide step worth of combinational datapath.
    always_comb begin
        shift_s    = {acc_r[31:0], a_r[31]};
        diff_s     = {1'b0, shift_s} - {2'b00, b_r};
        qbit_s     = ~diff_s[33];
        prod_add_s = acc_r + (b_r[0] ? a_r : 64'd0);
    end

    // Sign fix-up of the raw magnitude result.
    always_comb begin
        fix_hi_s = 32'd0;
        fix_lo_s = 32'd0;
        if (div0_r) begin
            fix_hi_s = a_r[31:0];
            fix_lo_s = 32'hFFFF_FFFF;
        end else begin
            case (op_r)
                2'b00: begin
                    fix_hi_s = (sign_a_r ^ sign_b_r) ? neg64(acc_r) >> 32 : acc_r[63:32];
                    fix_lo_s = (sign_a_r ^ sign_b_r) ? neg64(acc_r) : acc_r[31:0];
                end
                2'b01: begin
                    fix_hi_s = acc_r[63:32];
                    fix_lo_s = acc_r[31:0];
                end
                2'b10: begin
                    fix_hi_s = sign_a_r ? neg32(acc_r[31:0]) : acc_r[31:0];
                    fix_lo_s = (sign_a_r ^ sign_b_r) ? neg32(a_r[31:0]) : a_r[31:0];
                end
                default: begin
                    fix_hi_s = acc_r[31:0];
                    fix_lo_s = a_r[31:0];
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = div0_s ? FIX : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (flush) begin
                    state_s = IDLE;
                end else if (cnt_r == 5'd31) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX: begin
                if (flush) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Control outputs; write enables are squashed by a flush in the DONE cycle.
    always_comb begin
        stallreq = rst && (accept_s || (state_r == CALC) || (state_r == FIX));
        busy     = (state_r != IDLE);
        done     = (state_r == DONE);
        hi_we    = done && !flush;
        lo_we    = done && !flush;
        hi_o     = hi_r;
        lo_o     = lo_r;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= 5'd0;
            op_r     <= 2'd0;
            a_r      <= 64'd0;
            acc_r    <= 64'd0;
            b_r      <= 32'd0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            div0_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r  <= op;
                        cnt_r <= 5'd0;
                        acc_r <= 64'd0;
                        if (div0_s) begin
                            div0_r   <= 1'b1;
                            a_r      <= {32'd0, src_a};
                            b_r      <= 32'd0;
                            sign_a_r <= 1'b0;
                            sign_b_r <= 1'b0;
                        end else begin
                            div0_r   <= 1'b0;
                            a_r      <= {32'd0, mag32(src_a, !op[0])};
                            b_r      <= mag32(src_b, !op[0]);
                            sign_a_r <= !op[0] && src_a[31];
                            sign_b_r <= !op[0] && src_b[31];
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                CALC: begin
                    cnt_r <= cnt_r + 5'd1;
                    if (op_r[1]) begin
                        acc_r <= {31'd0, (qbit_s ? diff_s[32:0] : shift_s)};
                        a_r   <= {32'd0, a_r[30:0], qbit_s};
                    end else begin
                        acc_r <= prod_add_s;
                        a_r   <= a_r << 1;
                        b_r   <= b_r >> 1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
                    end else begin
                        hi_r <= hi_r;
                    end
                end
                DONE:    cnt_r <= cnt_r;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule
